booking_request_arbiter: RTL and testbench

//   Shares one booking core (single book_req/result port) between N_REQ ticket kiosks.

---
 rtl/booking_request_arbiter.sv | 177 +++++++++++++++++
 tb/tb_booking_request_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booking_request_arbiter.sv
// -----------------------------------------------------------------------------
// booking_request_arbiter
//
// Shares one booking core between N_REQ ticket kiosks. Requests are picked
// round-robin. A request with invalid fields (zero tickets, or source not
// below destination) is answered locally with an all-zero result and never
// reaches the core. No new grant is made while heal_trigger is high, but a
// transaction already under way always runs to completion.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   kiosk_req           per-kiosk request level
//   kiosk_train_id/src/dest/num   per-kiosk packed payload (kiosk i in slice i)
//   heal_trigger        high: hold off new grants
//   core_success/booked_count/fare   core result, valid CORE_LAT cycles after strobe
//   core_book_req       one-cycle strobe to the core
//   core_train_id/src/dest/num_tickets   registered payload to the core
//   kiosk_grant         one-hot pulse: winner's payload has been taken
//   kiosk_done          one-hot pulse: resp_* valid for that kiosk
//   resp_success/booked_count/fare   result returned to the kiosk
//   busy                high whenever a transaction is in progress
//   rej_count           saturating count of locally rejected requests
// -----------------------------------------------------------------------------
module booking_request_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CORE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   kiosk_req,
    input  logic [N_REQ-1:0]   kiosk_train_id,
    input  logic [N_REQ*3-1:0] kiosk_src,
    input  logic [N_REQ*3-1:0] kiosk_dest,
    input  logic [N_REQ*4-1:0] kiosk_num,
    input  logic               heal_trigger,
    input  logic               core_success,
    input  logic [3:0]         core_booked_count,
    input  logic [9:0]         core_fare,
    output logic               core_book_req,
    output logic               core_train_id,
    output logic [2:0]         core_src,
    output logic [2:0]         core_dest,
    output logic [3:0]         core_num_tickets,
    output logic [N_REQ-1:0]   kiosk_grant,
    output logic [N_REQ-1:0]   kiosk_done,
    output logic               resp_success,
    output logic [3:0]         resp_booked_count,
    output logic [9:0]         resp_fare,
    output logic               busy,
    output logic [7:0]         rej_count
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Per-kiosk payload fields unpacked from the flat buses
    logic [2:0]       src_arr  [N_REQ];
    logic [2:0]       dest_arr [N_REQ];
    logic [3:0]       num_arr  [N_REQ];
    logic [N_REQ-1:0] req_ok;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fields
        assign src_arr[gi]  = kiosk_src[3*gi +: 3];
        assign dest_arr[gi] = kiosk_dest[3*gi +: 3];
        assign num_arr[gi]  = kiosk_num[4*gi +: 4];
        assign req_ok[gi]   = (num_arr[gi] != 4'd0) && (src_arr[gi] < dest_arr[gi]);
    end

    state_t           state_reg;
    logic [PW-1:0]    rr_ptr_reg;
    logic [N_REQ-1:0] winner_reg;
    logic [CW-1:0]    wait_cnt_reg;

    // Round-robin search: first asserted request at rr_ptr, rr_ptr+1, ...
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    win_next_ptr;
    logic [N_REQ-1:0] win_onehot;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int o = 0; o < N_REQ; o++) begin
            cand = PW'((int'(rr_ptr_reg) + o) % N_REQ);
            if (!win_found && kiosk_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_next_ptr = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= '0;
            winner_reg        <= '0;
            wait_cnt_reg      <= '0;
            core_book_req     <= 1'b0;
            core_train_id     <= 1'b0;
            core_src          <= '0;
            core_dest         <= '0;
            core_num_tickets  <= '0;
            kiosk_grant       <= '0;
            kiosk_done        <= '0;
            resp_success      <= 1'b0;
            resp_booked_count <= '0;
            resp_fare         <= '0;
            busy              <= 1'b0;
            rej_count         <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            core_book_req <= 1'b0;
            kiosk_grant   <= '0;
            kiosk_done    <= '0;
            case (state_reg)
                IDLE: begin
                    if (!heal_trigger && win_found) begin
                        winner_reg  <= win_onehot;
                        rr_ptr_reg  <= win_next_ptr;
                        kiosk_grant <= win_onehot;
                        busy        <= 1'b1;
                        if (req_ok[win_idx]) begin
                            core_book_req    <= 1'b1;
                            core_train_id    <= kiosk_train_id[win_idx];
                            core_src         <= src_arr[win_idx];
                            core_dest        <= dest_arr[win_idx];
                            core_num_tickets <= num_arr[win_idx];
                            state_reg        <= ISSUE;
                        end else begin
                            // Local reject: grant and done land in the same cycle
                            kiosk_done        <= win_onehot;
                            resp_success      <= 1'b0;
                            resp_booked_count <= '0;
                            resp_fare         <= '0;
                            if (rej_count != 8'hFF) begin
                                rej_count <= rej_count + 8'd1;
                            end
                            state_reg <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= CW'(CORE_LAT - 1);
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    // Counter reaches 0 in the cycle CORE_LAT after the strobe
                    if (wait_cnt_reg == '0) begin
                        resp_success      <= core_success;
                        resp_booked_count <= core_booked_count;
                        resp_fare         <= core_fare;
                        kiosk_done        <= winner_reg;
                        state_reg         <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booking_request_arbiter.sv
module tb_booking_request_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     kiosk_req = '0;
    logic [N-1:0]     kiosk_train_id = '0;
    logic [N*3-1:0]   kiosk_src = '0;
    logic [N*3-1:0]   kiosk_dest = '0;
    logic [N*4-1:0]   kiosk_num = '0;
    logic             heal_trigger = 1'b0;
    logic             core_success = 1'b0;
    logic [3:0]       core_booked_count = '0;
    logic [9:0]       core_fare = '0;
    logic             core_book_req;
    logic             core_train_id;
    logic [2:0]       core_src;
    logic [2:0]       core_dest;
    logic [3:0]       core_num_tickets;
    logic [N-1:0]     kiosk_grant;
    logic [N-1:0]     kiosk_done;
    logic             resp_success;
    logic [3:0]       resp_booked_count;
    logic [9:0]       resp_fare;
    logic             busy;
    logic [7:0]       rej_count;

    booking_request_arbiter #(.N_REQ(N), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .kiosk_req(kiosk_req), .kiosk_train_id(kiosk_train_id),
        .kiosk_src(kiosk_src), .kiosk_dest(kiosk_dest), .kiosk_num(kiosk_num),
        .heal_trigger(heal_trigger),
        .core_success(core_success), .core_booked_count(core_booked_count), .core_fare(core_fare),
        .core_book_req(core_book_req), .core_train_id(core_train_id),
        .core_src(core_src), .core_dest(core_dest), .core_num_tickets(core_num_tickets),
        .kiosk_grant(kiosk_grant), .kiosk_done(kiosk_done),
        .resp_success(resp_success), .resp_booked_count(resp_booked_count), .resp_fare(resp_fare),
        .busy(busy), .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int kiosk; int cyc; bit book; logic [10:0] payload; } grant_t;
    typedef struct { int kiosk; int cyc; logic [14:0] res; logic [7:0] rej; } done_t;
    typedef struct { int cyc; logic [14:0] res; } core_t;

    grant_t gq[$];
    done_t  dq[$];
    core_t  cq[$];

    // Kiosk-side stimulus state and reference-model state
    logic [N-1:0] k_pend = '0;
    logic         k_tid  [N];
    logic [2:0]   k_src  [N];
    logic [2:0]   k_dest [N];
    logic [3:0]   k_num  [N];
    logic         heal_v = 1'b0;
    logic         rst_v  = 1'b0;
    int           m_ptr = 0;
    int           m_idle_at = 0;
    int           m_rej = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, 32'(kiosk_grant), 0);
        chk({tag, "_done"},  32'(kiosk_done), 0);
        chk({tag, "_book"},  32'(core_book_req), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_rej"},   32'(rej_count), 0);
        chk({tag, "_resp"},  32'({resp_success, resp_booked_count, resp_fare}), 0);
        chk({tag, "_core"},  32'({core_train_id, core_src, core_dest, core_num_tickets}), 0);
    endtask

    // One clock cycle of stimulus: drive inputs shortly after the falling edge,
    // play the booking core, and let the model decide what the arbiter must do.
    task automatic step();
        core_t c;
        @(negedge clk);
        #1;
        rst_n        = rst_v;
        heal_trigger = heal_v;
        kiosk_req    = k_pend;
        for (int i = 0; i < N; i++) begin
            kiosk_train_id[i]  = k_tid[i];
            kiosk_src[3*i +: 3]  = k_src[i];
            kiosk_dest[3*i +: 3] = k_dest[i];
            kiosk_num[4*i +: 4]  = k_num[i];
        end
        while (cq.size() > 0 && cq[0].cyc < cyc) void'(cq.pop_front());
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            c = cq.pop_front();
            {core_success, core_booked_count, core_fare} = c.res;
        end else begin
            {core_success, core_booked_count, core_fare} = 15'($urandom);
        end
        if (!rst_v) begin
            gq.delete(); dq.delete(); cq.delete();
            m_ptr = 0; m_rej = 0; m_idle_at = cyc + 1;
        end else if (cyc >= m_idle_at && !heal_v && k_pend != 0) begin
            int w;
            logic [14:0] res;
            w = 0;
            for (int o = N - 1; o >= 0; o--)
                if (k_pend[(m_ptr + o) % N]) w = (m_ptr + o) % N;
            m_ptr = (w + 1) % N;
            if (k_num[w] != 0 && k_src[w] < k_dest[w]) begin
                res = 15'($urandom);
                gq.push_back('{w, cyc + 1, 1'b1, {k_tid[w], k_src[w], k_dest[w], k_num[w]}});
                cq.push_back('{cyc + 1 + LAT, res});
                dq.push_back('{w, cyc + LAT + 2, res, 8'(m_rej)});
                m_idle_at = cyc + LAT + 3;
            end else begin
                if (m_rej < 255) m_rej++;
                gq.push_back('{w, cyc + 1, 1'b0, 11'd0});
                dq.push_back('{w, cyc + 1, 15'd0, 8'(m_rej)});
                m_idle_at = cyc + 2;
            end
            k_pend[w] = 1'b0;
        end
    endtask

    task automatic rand_kiosks();
        for (int i = 0; i < N; i++) begin
            if (!k_pend[i]) begin
                k_tid[i] = 1'($urandom);
                if ($urandom_range(0, 2) != 0) begin
                    k_src[i]  = 3'($urandom_range(0, 6));
                    k_dest[i] = 3'($urandom_range(int'(k_src[i]) + 1, 7));
                    k_num[i]  = 4'($urandom_range(1, 15));
                end else begin
                    k_src[i]  = 3'($urandom);
                    k_dest[i] = 3'($urandom);
                    k_num[i]  = 4'($urandom);
                end
                if ($urandom_range(0, 3) == 0) k_pend[i] = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
                k_pend[i] = 1'b0;
            end
        end
        if ($urandom_range(0, 15) == 0) heal_v = ~heal_v;
    endtask

    task automatic set_kiosk(input int i, input int s, input int d, input int n);
        k_tid[i] = 1'(i); k_src[i] = 3'(s); k_dest[i] = 3'(d); k_num[i] = 4'(n);
    endtask

    task automatic drain();
        int n;
        heal_v = 1'b0;
        n = 0;
        while ((k_pend != 0 || gq.size() > 0 || dq.size() > 0 || cyc < m_idle_at) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout actual=pending required=idle cyc=%0d", cyc);
        end
        step(); step();
    endtask

    // Monitor: pops expected grants/dones whenever the DUT presents them
    always @(negedge clk) begin
        grant_t g;
        done_t  d;
        if (gq.size() > 0 && gq[0].cyc < cyc) begin
            g = gq.pop_front();
            checks++; errors++;
            $display("FAIL grant_missing actual=none required=kiosk%0d at cyc %0d", g.kiosk, g.cyc);
        end
        if (dq.size() > 0 && dq[0].cyc < cyc) begin
            d = dq.pop_front();
            checks++; errors++;
            $display("FAIL done_missing actual=none required=kiosk%0d at cyc %0d", d.kiosk, d.cyc);
        end
        if (kiosk_grant != 0 || core_book_req) begin
            if (gq.size() == 0 || gq[0].cyc != cyc) begin
                checks++; errors++;
                $display("FAIL grant_unexpected actual=grant %b book %b required=none cyc=%0d",
                         kiosk_grant, core_book_req, cyc);
            end else begin
                g = gq.pop_front();
                chk("grant_onehot", 32'(kiosk_grant), 32'(1) << g.kiosk);
                chk("core_book_req", 32'(core_book_req), 32'(g.book));
                if (g.book)
                    chk("core_payload", 32'({core_train_id, core_src, core_dest, core_num_tickets}),
                        32'(g.payload));
                chk("busy_at_grant", 32'(busy), 1);
            end
        end
        if (kiosk_done != 0) begin
            if (dq.size() == 0 || dq[0].cyc != cyc) begin
                checks++; errors++;
                $display("FAIL done_unexpected actual=done %b required=none cyc=%0d", kiosk_done, cyc);
            end else begin
                d = dq.pop_front();
                chk("done_onehot", 32'(kiosk_done), 32'(1) << d.kiosk);
                chk("resp_fields", 32'({resp_success, resp_booked_count, resp_fare}), 32'(d.res));
                chk("rej_count", 32'(rej_count), 32'(d.rej));
                chk("busy_at_done", 32'(busy), 1);
                $display("txn kiosk=%0d cyc=%0d success=%0d count=%0d fare=%0d rej=%0d",
                         d.kiosk, cyc, resp_success, resp_booked_count, resp_fare, rej_count);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) set_kiosk(i, 0, 0, 0);

        // Reset state
        rst_v = 1'b0;
        repeat (3) step();
        #1 check_zero("reset");
        rst_v = 1'b1;
        step();

        // Single valid booking from kiosk 0
        set_kiosk(0, 1, 4, 2);
        k_pend = 4'b0001;
        drain();

        // All kiosks requesting: round-robin order, twice round
        for (int i = 0; i < N; i++) set_kiosk(i, i % 4, 5 + (i % 3), i + 1);
        k_pend = 4'b1111;
        drain();
        k_pend = 4'b1111;
        drain();

        // Local rejects: src > dest, then zero tickets
        set_kiosk(2, 5, 2, 3);
        k_pend = 4'b0100;
        drain();
        set_kiosk(1, 1, 3, 0);
        k_pend = 4'b0010;
        drain();

        // heal_trigger holds off grant; rising mid-transaction does not abort it
        heal_v = 1'b1;
        set_kiosk(1, 0, 7, 5);
        k_pend = 4'b0010;
        repeat (6) step();
        heal_v = 1'b0;
        while (k_pend != 0) step();
        step();
        heal_v = 1'b1;
        repeat (6) step();
        drain();

        // Reset while waiting on the core; pending requests then served from index 0
        set_kiosk(1, 2, 6, 3);
        k_pend = 4'b0010;
        while (k_pend != 0) step();
        step(); step();
        rst_v = 1'b0;
        set_kiosk(3, 0, 1, 1);
        k_pend = 4'b1010;
        step();
        #1 check_zero("midreset");
        step();
        rst_v = 1'b1;
        drain();

        // Randomised traffic
        repeat (1500) begin
            rand_kiosks();
            step();
        end
        drain();

        // Reject counter saturation
        k_pend = '0;
        repeat (600) begin
            if (!k_pend[0]) begin
                set_kiosk(0, 1, 3, 0);
                k_pend[0] = 1'b1;
            end
            step();
        end
        k_pend = '0;
        drain();
        chk("rej_saturated", 32'(rej_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
